// File: rtl/polymult_seq.sv
// rtl/polymult_seq.sv - sparse polynomial multiply sequencer with dummy-slot interleaving
// Every slot, real or dummy, takes FETCH/READ/ISSUE so power/timing traces cannot separate them.
module polymult_seq #(
    parameter int pWEIGHT = 66,
    parameter int pDUMMY  = 16,
    parameter int pPOS_W  = 15,
    parameter int pADDR_W = 7,
    parameter int pN      = 17669
) (
    input  logic               crypto_clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               trig_en_i,
    input  logic               rnd_i,
    output logic [pADDR_W-1:0] pos_addr_o,
    input  logic [pPOS_W-1:0]  pos_rdata_i,
    output logic               acc_clear_o,
    output logic               op_valid_o,
    input  logic               op_ready_i,
    output logic [pPOS_W-1:0]  op_pos_o,
    output logic               op_dummy_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               trigger_o,
    output logic               err_o
);

    localparam int RW = $clog2(pWEIGHT + 1);
    localparam int DW = (pDUMMY > 0) ? $clog2(pDUMMY + 1) : 1;
    localparam logic [pPOS_W:0] N_L = (pPOS_W + 1)'(pN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_READ,
        S_ISSUE,
        S_FINISH
    } state_t;

    state_t             state_q;
    logic [RW-1:0]      real_left_q;
    logic [DW-1:0]      dummy_left_q;
    logic [pADDR_W-1:0] pos_addr_q;
    logic [pPOS_W-1:0]  op_pos_q;
    logic               op_dummy_q;
    logic               op_valid_q;
    logic               acc_clear_q;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               trigger_q;
    logic               err_q;
    logic               last_slot;

    // Trigger tracks the next-cycle busy value so it lines up with busy_o yet stays registered.
    always_comb begin
        busy_d = busy_q;
        case (state_q)
            S_IDLE:   busy_d = start_i;
            S_FINISH: busy_d = 1'b0;
            default:  busy_d = 1'b1;
        endcase
    end

    always_comb begin
        last_slot = 1'b0;
        if (op_dummy_q) begin
            last_slot = (dummy_left_q == DW'(1)) && (real_left_q == '0);
        end else begin
            last_slot = (real_left_q == RW'(1)) && (dummy_left_q == '0);
        end
    end

    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            real_left_q  <= '0;
            dummy_left_q <= '0;
            pos_addr_q   <= '0;
            op_pos_q     <= '0;
            op_dummy_q   <= 1'b0;
            op_valid_q   <= 1'b0;
            acc_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trigger_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= busy_d;
            trigger_q   <= busy_d && trig_en_i;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_CLEAR;
                        acc_clear_q  <= 1'b1;
                        real_left_q  <= RW'(pWEIGHT);
                        dummy_left_q <= DW'(pDUMMY);
                        pos_addr_q   <= '0;
                        op_pos_q     <= '0;
                        op_dummy_q   <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (dummy_left_q == '0) begin
                        op_dummy_q <= 1'b0;
                    end else if (real_left_q == '0) begin
                        op_dummy_q <= 1'b1;
                    end else begin
                        op_dummy_q <= rnd_i;
                    end
                    state_q <= S_READ;
                end
                S_READ: begin
                    // Dummy slots leave the last real position on op_pos_o.
                    if (!op_dummy_q) begin
                        op_pos_q <= pos_rdata_i;
                        if ({1'b0, pos_rdata_i} >= N_L) begin
                            err_q <= 1'b1;
                        end
                    end
                    op_valid_q <= 1'b1;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (op_ready_i) begin
                        op_valid_q <= 1'b0;
                        if (op_dummy_q) begin
                            dummy_left_q <= dummy_left_q - 1'b1;
                        end else begin
                            real_left_q <= real_left_q - 1'b1;
                            pos_addr_q  <= pos_addr_q + 1'b1;
                        end
                        if (last_slot) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pos_addr_o  = pos_addr_q;
    assign op_pos_o    = op_pos_q;
    assign op_dummy_o  = op_dummy_q;
    assign op_valid_o  = op_valid_q;
    assign acc_clear_o = acc_clear_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign trigger_o   = trigger_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_polymult_seq.sv
// tb/tb_polymult_seq.sv - directed table-driven bench for polymult_seq
module tb_polymult_seq;

    localparam int W  = 3;
    localparam int D  = 2;
    localparam int PW = 15;
    localparam int AW = 7;
    localparam int NC = 26;

    logic          crypto_clk = 1'b0;
    logic          resetn     = 1'b0;
    logic          start_i    = 1'b0;
    logic          trig_en_i  = 1'b0;
    logic          rnd_i      = 1'b0;
    logic          op_ready_i = 1'b1;
    logic [PW-1:0] pos_rdata_i;
    logic [AW-1:0] pos_addr_o;
    logic          acc_clear_o;
    logic          op_valid_o;
    logic [PW-1:0] op_pos_o;
    logic          op_dummy_o;
    logic          busy_o;
    logic          done_o;
    logic          trigger_o;
    logic          err_o;

    polymult_seq #(
        .pWEIGHT(W),
        .pDUMMY (D),
        .pPOS_W (PW),
        .pADDR_W(AW),
        .pN     (17669)
    ) dut (
        .crypto_clk (crypto_clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .trig_en_i  (trig_en_i),
        .rnd_i      (rnd_i),
        .pos_addr_o (pos_addr_o),
        .pos_rdata_i(pos_rdata_i),
        .acc_clear_o(acc_clear_o),
        .op_valid_o (op_valid_o),
        .op_ready_i (op_ready_i),
        .op_pos_o   (op_pos_o),
        .op_dummy_o (op_dummy_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .trigger_o  (trigger_o),
        .err_o      (err_o)
    );

    always #5 crypto_clk = ~crypto_clk;

    logic [PW-1:0] ram [0:3];
    always @(posedge crypto_clk) pos_rdata_i <= ram[pos_addr_o[1:0]];

    typedef struct {
        string             name;
        bit                rnd;
        bit                trig;
        int                stall;
        logic [PW-1:0]     ram1;
        int                restart;
        logic [0:4][PW-1:0] pos;
        logic [0:4]        dum;
        logic [0:4][7:0]   hs;
        int                done;
        int                err_from;
    } vec_t;

    vec_t vecs [0:4];

    logic          t_valid [NC];
    logic          t_ready [NC];
    logic          t_dum   [NC];
    logic          t_acc   [NC];
    logic          t_busy  [NC];
    logic          t_done  [NC];
    logic          t_trig  [NC];
    logic          t_err   [NC];
    logic [PW-1:0] t_pos   [NC];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run(input bit rnd, input bit trig, input int stall, input int restart, input int rst_at);
        int stall_left;
        stall_left = stall;
        for (int c = 0; c < NC; c++) begin
            @(negedge crypto_clk);
            if (c == rst_at) begin
                resetn = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {op_valid_o, op_dummy_o, acc_clear_o, busy_o, done_o, trigger_o, err_o, op_pos_o, pos_addr_o}, 0);
            end
            t_valid[c] = op_valid_o;
            t_dum[c]   = op_dummy_o;
            t_acc[c]   = acc_clear_o;
            t_busy[c]  = busy_o;
            t_done[c]  = done_o;
            t_trig[c]  = trigger_o;
            t_err[c]   = err_o;
            t_pos[c]   = op_pos_o;
            start_i    = (c == 0) || (c == restart);
            rnd_i      = rnd;
            trig_en_i  = trig;
            if (op_valid_o && stall_left > 0) begin
                op_ready_i = 1'b0;
                stall_left--;
            end else begin
                op_ready_i = 1'b1;
            end
            t_ready[c] = op_ready_i;
        end
        start_i = 1'b0;
    endtask

    task automatic check_vec(input vec_t v);
        int  k;
        bit  eb;
        k = 0;
        for (int c = 1; c < NC; c++) begin
            eb = (c <= v.done);
            chk({v.name, "_busy"}, t_busy[c], eb);
            chk({v.name, "_done"}, t_done[c], c == v.done);
            chk({v.name, "_acc_clear"}, t_acc[c], c == 1);
            chk({v.name, "_trigger"}, t_trig[c], v.trig && eb);
            chk({v.name, "_err"}, t_err[c], (v.err_from != 0) && (c >= v.err_from));
            if (t_valid[c]) begin
                if (k < 5) begin
                    chk({v.name, "_op_pos"}, t_pos[c], v.pos[k]);
                    chk({v.name, "_op_dummy"}, t_dum[c], v.dum[k]);
                    if (t_ready[c]) begin
                        chk({v.name, "_handshake_cycle"}, c, v.hs[k]);
                        k++;
                    end
                end else begin
                    chk({v.name, "_extra_op_valid"}, 1, 0);
                end
            end
        end
        chk({v.name, "_op_count"}, k, 5);
    endtask

    initial begin
        ram[0] = 15'd5;
        ram[1] = 15'd9;
        ram[2] = 15'd12;
        ram[3] = 15'd0;

        vecs[0] = '{"basic", 1'b0, 1'b1, 0, 15'd9, -1,
                    {15'd5, 15'd9, 15'd12, 15'd12, 15'd12}, 5'b00011,
                    {8'd4, 8'd7, 8'd10, 8'd13, 8'd16}, 17, 0};
        vecs[1] = '{"rnd_dummy_first", 1'b1, 1'b1, 0, 15'd9, -1,
                    {15'd0, 15'd0, 15'd5, 15'd9, 15'd12}, 5'b11000,
                    {8'd4, 8'd7, 8'd10, 8'd13, 8'd16}, 17, 0};
        vecs[2] = '{"stall4", 1'b0, 1'b1, 4, 15'd9, -1,
                    {15'd5, 15'd9, 15'd12, 15'd12, 15'd12}, 5'b00011,
                    {8'd8, 8'd11, 8'd14, 8'd17, 8'd20}, 21, 0};
        vecs[3] = '{"restart_range_err", 1'b0, 1'b1, 0, 15'd20000, 8,
                    {15'd5, 15'd20000, 15'd12, 15'd12, 15'd12}, 5'b00011,
                    {8'd4, 8'd7, 8'd10, 8'd13, 8'd16}, 17, 7};
        vecs[4] = '{"trig_off", 1'b0, 1'b0, 0, 15'd9, -1,
                    {15'd5, 15'd9, 15'd12, 15'd12, 15'd12}, 5'b00011,
                    {8'd4, 8'd7, 8'd10, 8'd13, 8'd16}, 17, 0};

        repeat (2) @(negedge crypto_clk);
        #1;
        chk("reset_state",
            {op_valid_o, op_dummy_o, acc_clear_o, busy_o, done_o, trigger_o, err_o, op_pos_o, pos_addr_o}, 0);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            ram[1] = vecs[i].ram1;
            run(vecs[i].rnd, vecs[i].trig, vecs[i].stall, vecs[i].restart, -1);
            check_vec(vecs[i]);
        end

        ram[1] = 15'd9;
        run(1'b0, 1'b1, 0, -1, 9);
        for (int c = 1; c < NC; c++) begin
            chk("abort_no_done", t_done[c], 0);
            if (c >= 9) begin
                chk("abort_busy_low", t_busy[c], 0);
            end
        end
        @(negedge crypto_clk);
        resetn = 1'b1;
        run(vecs[0].rnd, vecs[0].trig, 0, -1, -1);
        check_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
